tmds_encoder: RTL and testbench

Single-channel TMDS (DVI 1.0) 8b/10b encoder sitting directly downstream of the TFT timing controller in the HDMI path. It consumes one 8-bit colour component plus `tft_de`/`hsync`/`vsync` and produces a DC-balanced 10-bit symbol per pixel clock for the serializer. The top level instantiates it three times: blue with c0=hsync and c1=vsync, and green/red with c0=c1=0.

---
 rtl/tmds_encoder_if.sv | 12 +
 rtl/tmds_encoder.sv | 132 +++++++++++++
 tb/tb_tmds_encoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle for one TMDS channel: colour component, data enable,
// control bits in; 10-bit symbol out.
interface tmds_encoder_if;
    logic       de;
    logic       c0;
    logic       c1;
    logic [7:0] din;
    logic [9:0] dout;

    modport master (output de, c0, c1, din, input dout);
    modport slave  (input de, c0, c1, din, output dout);
endinterface

// File: rtl/tmds_encoder.sv
// DVI 8b/10b TMDS channel encoder: transition minimisation plus DC balance.
// Latency: inputs at edge N appear on dout after edge N+2; no backpressure, one symbol per clock.
module tmds_encoder (
    input  logic          tft_clk,
    input  logic          sys_rst_n,
    tmds_encoder_if.slave bus
);

    function automatic logic [3:0] f_popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [8:0] f_trans_min(input logic [7:0] d, input logic use_xnor);
        logic [8:0] q;
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Stage 1
    logic [7:0] r_din1;
    logic       r_de1, r_c0_1, r_c1_1;
    logic [3:0] r_n1d;

    // Stage 2
    logic [8:0] r_qm;
    logic [3:0] r_n1q, r_n0q;
    logic       r_de2, r_c0_2, r_c1_2;

    // Stage 3
    logic [9:0] r_dout;
    logic [5:0] r_cnt;

    logic       w_use_xnor;
    logic [8:0] w_qm;
    logic [3:0] w_n1q;
    logic [5:0] w_n1q6, w_n0q6, w_diff10, w_diff01, w_qm8x2, w_nqm8x2;
    logic       w_cnt_pos;
    logic [9:0] w_dout_next;
    logic [5:0] w_cnt_next;

    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_din1 <= 8'd0;
            r_de1  <= 1'b0;
            r_c0_1 <= 1'b0;
            r_c1_1 <= 1'b0;
            r_n1d  <= 4'd0;
        end else begin
            r_din1 <= bus.din;
            r_de1  <= bus.de;
            r_c0_1 <= bus.c0;
            r_c1_1 <= bus.c1;
            r_n1d  <= f_popcount8(bus.din);
        end
    end

    assign w_use_xnor = (r_n1d > 4'd4) || ((r_n1d == 4'd4) && !r_din1[0]);
    assign w_qm       = f_trans_min(r_din1, w_use_xnor);
    assign w_n1q      = f_popcount8(w_qm[7:0]);

    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_qm   <= 9'd0;
            r_n1q  <= 4'd0;
            r_n0q  <= 4'd0;
            r_de2  <= 1'b0;
            r_c0_2 <= 1'b0;
            r_c1_2 <= 1'b0;
        end else begin
            r_qm   <= w_qm;
            r_n1q  <= w_n1q;
            r_n0q  <= 4'd8 - w_n1q;
            r_de2  <= r_de1;
            r_c0_2 <= r_c0_1;
            r_c1_2 <= r_c1_1;
        end
    end

    // Disparity arithmetic is 6-bit two's complement; wrap-around is the signed result.
    assign w_n1q6    = {2'b00, r_n1q};
    assign w_n0q6    = {2'b00, r_n0q};
    assign w_diff10  = w_n1q6 - w_n0q6;
    assign w_diff01  = w_n0q6 - w_n1q6;
    assign w_qm8x2   = {4'b0000, r_qm[8], 1'b0};
    assign w_nqm8x2  = {4'b0000, ~r_qm[8], 1'b0};
    assign w_cnt_pos = !r_cnt[5] && (r_cnt != 6'd0);

    always_comb begin
        w_dout_next = 10'd0;
        w_cnt_next  = r_cnt;
        if (r_de2) begin
            if ((r_cnt == 6'd0) || (r_n1q == r_n0q)) begin
                w_dout_next = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt_next  = r_cnt + (r_qm[8] ? w_diff10 : w_diff01);
            end else if ((w_cnt_pos && (r_n1q > r_n0q)) || (r_cnt[5] && (r_n0q > r_n1q))) begin
                w_dout_next = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_cnt_next  = r_cnt + w_qm8x2 + w_diff01;
            end else begin
                w_dout_next = {1'b0, r_qm[8], r_qm[7:0]};
                w_cnt_next  = r_cnt + w_diff10 - w_nqm8x2;
            end
        end else begin
            w_cnt_next = 6'd0;
            case ({r_c1_2, r_c0_2})
                2'b00:   w_dout_next = 10'b1101010100;
                2'b01:   w_dout_next = 10'b0010101011;
                2'b10:   w_dout_next = 10'b0101010100;
                default: w_dout_next = 10'b1010101011;
            endcase
        end
    end

    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dout <= 10'd0;
            r_cnt  <= 6'd0;
        end else begin
            r_dout <= w_dout_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign bus.dout = r_dout;

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed known symbols plus a random
// burst run checked against a symbol-level disparity model.
module tb_tmds_encoder;

    logic tft_clk;
    logic sys_rst_n;

    tmds_encoder_if bus();

    tmds_encoder dut (
        .tft_clk   (tft_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial tft_clk = 1'b0;
    always #5 tft_clk = ~tft_clk;

    typedef struct {
        logic [9:0] d;
        bit         is_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 0;
    int   m_cnt    = 0;
    int   mon_disp = 0;

    // Reference: pick the inversion from the disparity rules, then track the
    // running disparity as ones-minus-zeros of each emitted 10-bit symbol.
    function automatic void model(input logic de, input logic c1, input logic c0,
                                  input logic [7:0] d, input int cnt_in,
                                  output logic [9:0] sym, output int cnt_out);
        logic [7:0] q;
        bit q8, xn, inv;
        int n1, a, b;
        if (!de) begin
            case ({c1, c0})
                2'b00:   sym = 10'b1101010100;
                2'b01:   sym = 10'b0010101011;
                2'b10:   sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
            cnt_out = 0;
            return;
        end
        n1   = $countones(d);
        xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q8 = !xn;
        a  = $countones(q);
        b  = 8 - a;
        if (cnt_in == 0 || a == b)                          inv = !q8;
        else if ((cnt_in > 0 && a > b) || (cnt_in < 0 && b > a)) inv = 1'b1;
        else                                                 inv = 1'b0;
        sym     = {inv, q8, inv ? ~q : q};
        cnt_out = cnt_in + 2 * $countones(sym) - 10;
    endfunction

    task automatic step(input logic de, input logic c1, input logic c0,
                        input logic [7:0] d, input bit hard, input logic [9:0] hval);
        logic [9:0] s;
        int nc;
        exp_t e;
        model(de, c1, c0, d, m_cnt, s, nc);
        m_cnt     = nc;
        bus.de    = de;
        bus.c1    = c1;
        bus.c0    = c0;
        bus.din   = d;
        e.d       = hard ? hval : s;
        e.is_data = de;
        sb.push_back(e);
        @(posedge tft_clk);
        #1;
    endtask

    // Release just after a falling edge; the flushed pipeline yields two {00} tokens.
    task automatic release_reset();
        exp_t e;
        @(negedge tft_clk);
        #1;
        sys_rst_n = 1'b1;
        m_cnt     = 0;
        e.d       = 10'h354;
        e.is_data = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        mon_en    = 1'b1;
    endtask

    task automatic async_reset_pulse();
        #2;
        sys_rst_n = 1'b0;
        mon_en    = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (bus.dout !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset_dout got %h need %h", bus.dout, 10'h000);
        end
        release_reset();
    endtask

    always @(negedge tft_clk) begin
        if (mon_en) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow got %h with nothing expected", bus.dout);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (bus.dout !== e.d) begin
                    n_fail++;
                    $display("FAIL dout got %h need %h", bus.dout, e.d);
                end
                if (e.is_data) begin
                    mon_disp = mon_disp + 2 * $countones(bus.dout) - 10;
                    n_checks++;
                    if (mon_disp > 10 || mon_disp < -10) begin
                        n_fail++;
                        $display("FAIL disparity got %0d need within -10..10", mon_disp);
                    end
                end else begin
                    mon_disp = 0;
                end
            end
        end
    end

    initial begin
        int rem;
        logic cur_de;
        logic [1:0] cc;
        logic [7:0] rd;

        sys_rst_n = 1'b0;
        bus.de    = 1'b0;
        bus.c0    = 1'b0;
        bus.c1    = 1'b0;
        bus.din   = 8'h00;
        #22;
        n_checks++;
        if (bus.dout !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_dout got %h need %h", bus.dout, 10'h000);
        end

        release_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h354);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 10'h0AB);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 10'h154);
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 10'h2AB);
        // Zero run from cnt=0: -8, +2, -6
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h100);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h3FF);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h100);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h354);
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 10'h200);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h354);
        // Blanking between two zero pixels restarts disparity at 0
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h100);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 10'h354);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 10'h100);

        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom_range(0, 255));
            step(1'(i % 2), 1'b0, 1'b1, rd, 1'b0, 10'h000);
        end

        for (int i = 0; i < 20; i++) begin
            rd = 8'($urandom_range(0, 255));
            step(1'b1, 1'b0, 1'b0, rd, 1'b0, 10'h000);
        end
        async_reset_pulse();
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom_range(0, 255));
            step(1'b1, 1'b0, 1'b0, rd, 1'b0, 10'h000);
        end

        rem    = 0;
        cur_de = 1'b0;
        cc     = 2'b00;
        for (int i = 0; i < 10000; i++) begin
            if (rem == 0) begin
                cur_de = ~cur_de;
                rem    = cur_de ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
                cc     = 2'($urandom_range(0, 3));
            end
            rem--;
            rd = 8'($urandom_range(0, 255));
            step(cur_de, cc[1], cc[0], rd, 1'b0, 10'h000);
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge tft_clk);
        mon_en = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending need 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
